// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: issues one req/ack bus transaction per load/store,
// raises mem_stall while it is outstanding and lane-aligns store data / extends load data.
module dmem_access_unit #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            re_mem,
  input  logic            we_mem,
  input  logic [XLEN-1:0] addr_mem,
  input  logic [XLEN-1:0] wdata_mem,
  input  logic [2:0]      funct3_mem,
  input  logic            flush_mem,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_wstrb,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic [XLEN-1:0] rdata_out,
  output logic            misalign,
  output logic            bus_timeout
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  localparam bit         LP_TMO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic            r_drop;
  logic            w_drop_next;
  logic [7:0]      r_cnt;
  logic [7:0]      w_cnt_next;

  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic            r_we;
  logic [7:0]      r_wstrb;
  logic [2:0]      r_funct3;
  logic [2:0]      r_off;

  logic            w_acc;
  logic            w_latch;
  logic            w_timeout_hit;
  logic [7:0]      w_strb_base;
  logic [7:0]      w_strb_lane;
  logic [XLEN-1:0] w_wdata_lane;
  logic [XLEN-1:0] w_rdata_shift;
  logic [XLEN-1:0] w_load_ext;
  logic            w_signed;

  // Natural alignment check on the incoming access; only meaningful when one is present.
  always_comb begin
    misalign = 1'b0;
    case (funct3_mem[1:0])
      2'b01:   misalign = addr_mem[0];
      2'b10:   misalign = |addr_mem[1:0];
      2'b11:   misalign = |addr_mem[2:0];
      default: misalign = 1'b0;
    endcase
    misalign = misalign & (re_mem | we_mem);
  end

  // Reset gates acc so mem_stall is low throughout reset even with a live access on the inputs.
  assign w_acc = (re_mem | we_mem) & ~misalign & ~flush_mem & ~rst;

  always_comb begin
    w_strb_base = 8'h00;
    case (funct3_mem[1:0])
      2'b00:   w_strb_base = 8'h01;
      2'b01:   w_strb_base = 8'h03;
      2'b10:   w_strb_base = 8'h0F;
      default: w_strb_base = 8'hFF;
    endcase
  end

  assign w_strb_lane  = w_strb_base << addr_mem[2:0];
  assign w_wdata_lane = wdata_mem << {addr_mem[2:0], 3'b000};

  assign w_rdata_shift = dmem_rdata >> {r_off, 3'b000};
  assign w_signed      = ~r_funct3[2];

  always_comb begin
    w_load_ext = w_rdata_shift;
    case (r_funct3[1:0])
      2'b00:   w_load_ext = {{(XLEN-8){w_signed & w_rdata_shift[7]}}, w_rdata_shift[7:0]};
      2'b01:   w_load_ext = {{(XLEN-16){w_signed & w_rdata_shift[15]}}, w_rdata_shift[15:0]};
      2'b10:   w_load_ext = {{(XLEN-32){w_signed & w_rdata_shift[31]}}, w_rdata_shift[31:0]};
      default: w_load_ext = w_rdata_shift;
    endcase
  end

  assign w_timeout_hit = LP_TMO_EN && (r_cnt == LP_CNT_LAST) && !dmem_ack;

  always_comb begin
    w_state_next = r_state;
    w_drop_next  = r_drop;
    w_cnt_next   = r_cnt;
    w_latch      = 1'b0;
    mem_stall    = 1'b0;
    dmem_req     = 1'b0;
    bus_timeout  = 1'b0;
    rdata_out    = '0;
    case (r_state)
      ST_IDLE: begin
        mem_stall = w_acc;
        if (w_acc) begin
          w_latch      = 1'b1;
          w_state_next = ST_WAIT;
          w_cnt_next   = 8'd0;
          w_drop_next  = 1'b0;
        end
      end
      ST_WAIT: begin
        dmem_req   = 1'b1;
        w_cnt_next = r_cnt + 8'd1;
        if (dmem_ack) begin
          w_state_next = ST_IDLE;
          w_drop_next  = 1'b0;
          if (!r_drop) begin
            if (!r_we) rdata_out = w_load_ext;
          end else begin
            // Squashed access: the stall now belongs to whatever instruction replaced it.
            mem_stall = re_mem | we_mem;
          end
        end else if (w_timeout_hit) begin
          bus_timeout  = 1'b1;
          w_state_next = ST_IDLE;
          w_drop_next  = 1'b0;
        end else begin
          mem_stall   = 1'b1;
          w_drop_next = r_drop | flush_mem;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_drop   <= 1'b0;
      r_cnt    <= 8'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_wstrb  <= 8'h00;
      r_funct3 <= 3'b000;
      r_off    <= 3'b000;
    end else begin
      r_state <= w_state_next;
      r_drop  <= w_drop_next;
      r_cnt   <= w_cnt_next;
      if (w_latch) begin
        r_addr   <= {addr_mem[XLEN-1:3], 3'b000};
        r_wdata  <= w_wdata_lane;
        r_we     <= we_mem;
        r_wstrb  <= w_strb_lane;
        r_funct3 <= funct3_mem;
        r_off    <= addr_mem[2:0];
      end
    end
  end

  // Bus payload comes only from the latched copy, so it holds steady for the whole WAIT.
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign dmem_wstrb = r_wstrb;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Randomised bench for dmem_access_unit: a byte-level model of lanes and extension,
// plus directed scenarios for flush/drop, timeout and mid-transaction reset.
module tb_dmem_access_unit;

  localparam int XLEN = 64;
  localparam int TMO  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            re_mem, we_mem, flush_mem;
  logic [XLEN-1:0] addr_mem, wdata_mem;
  logic [2:0]      funct3_mem;
  logic            dmem_req, dmem_we;
  logic [XLEN-1:0] dmem_addr, dmem_wdata;
  logic [7:0]      dmem_wstrb;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;
  logic            mem_stall;
  logic [XLEN-1:0] rdata_out;
  logic            misalign, bus_timeout;

  int n_checks = 0;
  int n_pass   = 0;

  dmem_access_unit #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .re_mem(re_mem), .we_mem(we_mem), .addr_mem(addr_mem), .wdata_mem(wdata_mem),
    .funct3_mem(funct3_mem), .flush_mem(flush_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .rdata_out(rdata_out),
    .misalign(misalign), .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (byte-level) ----------------
  function automatic logic [7:0] m_strb(input logic [2:0] f3, input logic [2:0] off);
    int n;
    logic [7:0] s;
    n = 1 << f3[1:0];
    s = '0;
    for (int b = 0; b < 8; b++)
      if (b >= int'(off) && b < int'(off) + n) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] wd, input logic [2:0] off);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < 8; b++)
      if (b >= int'(off)) r[b*8 +: 8] = wd[(b - int'(off))*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rd, input logic [2:0] f3,
                                         input logic [2:0] off);
    int n;
    logic [63:0] v;
    n = 1 << f3[1:0];
    v = '0;
    for (int i = 0; i < n; i++) v[i*8 +: 8] = rd[(int'(off) + i)*8 +: 8];
    if (!f3[2] && n < 8 && v[8*n-1]) v = v - (64'd1 << (8*n));
    return v;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    re_mem = 1'b0; we_mem = 1'b0; flush_mem = 1'b0; dmem_ack = 1'b0;
  endtask

  // One complete access with ack on WAIT cycle ack_k; every cycle is checked.
  task automatic do_access(input logic is_load, input logic [63:0] addr, input logic [63:0] wd,
                           input logic [2:0] f3, input int ack_k, input logic [63:0] rd,
                           input string tag);
    logic [63:0] exp_rd;
    logic        exp_stall;
    $display("txn %s %s addr=%h f3=%0d wd=%h ack_k=%0d rd=%h", tag, is_load ? "LD" : "ST",
             addr, f3, wd, ack_k, rd);
    re_mem = is_load; we_mem = ~is_load; addr_mem = addr; wdata_mem = wd;
    funct3_mem = f3; flush_mem = 1'b0; dmem_ack = 1'b0; dmem_rdata = rnd64();
    #2;
    n_checks++;
    if (mem_stall !== 1'b1 || dmem_req !== 1'b0 || misalign !== 1'b0 || rdata_out !== '0)
      $display("FAIL %s issue stall/req/mis/rd got %b%b%b %h want 1000", tag,
               mem_stall, dmem_req, misalign, rdata_out);
    else n_pass++;
    next_cycle();
    for (int k = 1; k <= ack_k; k++) begin
      dmem_ack   = (k == ack_k);
      dmem_rdata = (k == ack_k) ? rd : rnd64();
      #2;
      exp_rd    = (k == ack_k && is_load) ? m_load(rd, f3, addr[2:0]) : 64'd0;
      exp_stall = (k != ack_k);
      n_checks++;
      if (dmem_req !== 1'b1 || dmem_we !== ~is_load || dmem_addr !== {addr[63:3], 3'b000})
        $display("FAIL %s bus k=%0d req/we/addr got %b%b %h want 1%b %h", tag, k,
                 dmem_req, dmem_we, dmem_addr, ~is_load, {addr[63:3], 3'b000});
      else n_pass++;
      if (!is_load) begin
        n_checks++;
        if (dmem_wstrb !== m_strb(f3, addr[2:0]) || dmem_wdata !== m_wdata(wd, addr[2:0]))
          $display("FAIL %s lanes k=%0d got %h %h want %h %h", tag, k, dmem_wstrb, dmem_wdata,
                   m_strb(f3, addr[2:0]), m_wdata(wd, addr[2:0]));
        else n_pass++;
      end
      n_checks++;
      if (mem_stall !== exp_stall || bus_timeout !== 1'b0)
        $display("FAIL %s stall k=%0d got %b to=%b want %b to=0", tag, k, mem_stall,
                 bus_timeout, exp_stall);
      else n_pass++;
      n_checks++;
      if (rdata_out !== exp_rd)
        $display("FAIL %s rdata_out k=%0d got %h want %h", tag, k, rdata_out, exp_rd);
      else n_pass++;
      next_cycle();
    end
    clear_inputs();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    addr_mem = '0; wdata_mem = '0; funct3_mem = 3'b000; dmem_rdata = '0;
    repeat (2) next_cycle();
    #2;
    n_checks++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || bus_timeout !== 1'b0 || rdata_out !== '0
        || dmem_we !== 1'b0 || dmem_wstrb !== 8'h00)
      $display("FAIL reset outputs req=%b stall=%b to=%b rd=%h we=%b strb=%h want all 0",
               dmem_req, mem_stall, bus_timeout, rdata_out, dmem_we, dmem_wstrb);
    else n_pass++;
    rst = 1'b0;
    next_cycle();
    #2;
    n_checks++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0)
      $display("FAIL reset_idle req=%b stall=%b want 0 0", dmem_req, mem_stall);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_directed();
    do_access(1'b1, 64'h1004, 64'h0, 3'b010, 3, 64'h8000_0000_0000_0000, "lw_1004");
    do_access(1'b0, 64'h2003, 64'hAB, 3'b000, 1, 64'h0, "sb_2003");
  endtask

  task automatic test_misalign();
    int n, off;
    logic [2:0] f3;
    re_mem = 1'b1; we_mem = 1'b0; funct3_mem = 3'b001; addr_mem = 64'h3001; flush_mem = 1'b0;
    #2;
    n_checks++;
    if (misalign !== 1'b1 || dmem_req !== 1'b0 || mem_stall !== 1'b0)
      $display("FAIL lh_3001 mis/req/stall got %b%b%b want 100", misalign, dmem_req, mem_stall);
    else n_pass++;
    next_cycle();
    #2;
    n_checks++;
    if (dmem_req !== 1'b0) $display("FAIL lh_3001 no_issue req got %b want 0", dmem_req);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n   = 1 << $urandom_range(1, 3);
      off = n * $urandom_range(0, 8 / n - 1) + $urandom_range(1, n - 1);
      f3  = 3'(n == 2 ? 1 : (n == 4 ? 2 : 3));
      we_mem = $urandom_range(0, 1); re_mem = ~we_mem; funct3_mem = f3;
      addr_mem = {rnd64() & ~64'h7} | 64'(off);
      next_cycle();
      #2;
      $display("txn misalign n=%0d addr=%h we=%b", n, addr_mem, we_mem);
      n_checks++;
      if (misalign !== 1'b1 || mem_stall !== 1'b0 || dmem_req !== 1'b0)
        $display("FAIL misalign_rand mis/stall/req got %b%b%b want 100", misalign, mem_stall,
                 dmem_req);
      else n_pass++;
    end
    // flush in IDLE: aligned access present but squashed
    re_mem = 1'b1; we_mem = 1'b0; funct3_mem = 3'b011; addr_mem = 64'h3008; flush_mem = 1'b1;
    next_cycle();
    #2;
    n_checks++;
    if (mem_stall !== 1'b0 || misalign !== 1'b0)
      $display("FAIL flush_idle stall/mis got %b%b want 00", mem_stall, misalign);
    else n_pass++;
    next_cycle();
    #2;
    n_checks++;
    if (dmem_req !== 1'b0) $display("FAIL flush_idle req got %b want 0", dmem_req);
    else n_pass++;
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_flush_drop();
    logic [63:0] sd_data;
    sd_data = rnd64();
    $display("txn flush_drop LD 0x4000 flushed, SD 0x5008 data=%h", sd_data);
    re_mem = 1'b1; we_mem = 1'b0; funct3_mem = 3'b011; addr_mem = 64'h4000; flush_mem = 1'b0;
    #2;
    n_checks++;
    if (mem_stall !== 1'b1) $display("FAIL drop issue stall got %b want 1", mem_stall);
    else n_pass++;
    next_cycle();
    flush_mem = 1'b1;
    #2;
    n_checks++;
    if (mem_stall !== 1'b1 || dmem_req !== 1'b1)
      $display("FAIL drop wait1 stall/req got %b%b want 11", mem_stall, dmem_req);
    else n_pass++;
    next_cycle();
    flush_mem = 1'b0; re_mem = 1'b0; we_mem = 1'b1; addr_mem = 64'h5008; wdata_mem = sd_data;
    #2;
    n_checks++;
    if (mem_stall !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 64'h4000)
      $display("FAIL drop wait2 stall/we/addr got %b%b %h want 10 4000", mem_stall, dmem_we,
               dmem_addr);
    else n_pass++;
    next_cycle();
    dmem_ack = 1'b1; dmem_rdata = rnd64();
    #2;
    n_checks++;
    if (rdata_out !== '0 || mem_stall !== 1'b1)
      $display("FAIL drop ack rdata/stall got %h %b want 0 1", rdata_out, mem_stall);
    else n_pass++;
    next_cycle();
    dmem_ack = 1'b0;
    #2;
    n_checks++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b1)
      $display("FAIL drop sd_issue req/stall got %b%b want 01", dmem_req, mem_stall);
    else n_pass++;
    next_cycle();
    dmem_ack = 1'b1;
    #2;
    n_checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 64'h5008
        || dmem_wstrb !== 8'hFF || dmem_wdata !== sd_data || mem_stall !== 1'b0)
      $display("FAIL drop sd_bus got %b%b %h %h %h %b want 11 5008 ff %h 0", dmem_req, dmem_we,
               dmem_addr, dmem_wstrb, dmem_wdata, mem_stall, sd_data);
    else n_pass++;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_timeout();
    logic exp_to;
    $display("txn timeout LW 0x6000 no ack, TIMEOUT=%0d", TMO);
    re_mem = 1'b1; we_mem = 1'b0; funct3_mem = 3'b010; addr_mem = 64'h6000; dmem_ack = 1'b0;
    next_cycle();
    for (int k = 1; k <= TMO; k++) begin
      #2;
      exp_to = (k == TMO);
      n_checks++;
      if (bus_timeout !== exp_to || mem_stall !== ~exp_to || dmem_req !== 1'b1)
        $display("FAIL timeout k=%0d to/stall/req got %b%b%b want %b%b1", k, bus_timeout,
                 mem_stall, dmem_req, exp_to, ~exp_to);
      else n_pass++;
      next_cycle();
    end
    re_mem = 1'b0; dmem_ack = 1'b1; dmem_rdata = rnd64();
    #2;
    n_checks++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || rdata_out !== '0 || bus_timeout !== 1'b0)
      $display("FAIL late_ack req/stall/rd/to got %b%b %h %b want 00 0 0", dmem_req, mem_stall,
               rdata_out, bus_timeout);
    else n_pass++;
    next_cycle();
    dmem_ack = 1'b0;
    #2;
    n_checks++;
    if (dmem_req !== 1'b0) $display("FAIL late_ack after req got %b want 0", dmem_req);
    else n_pass++;
    do_access(1'b1, 64'h6008, 64'h0, 3'b100, 2, rnd64(), "lbu_after_to");
  endtask

  task automatic test_reset_mid();
    $display("txn reset_mid LW 0x7010");
    re_mem = 1'b1; we_mem = 1'b0; funct3_mem = 3'b010; addr_mem = 64'h7010; dmem_ack = 1'b0;
    next_cycle();
    #2;
    n_checks++;
    if (dmem_req !== 1'b1) $display("FAIL reset_mid pre req got %b want 1", dmem_req);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0)
      $display("FAIL reset_mid req/stall got %b%b want 00", dmem_req, mem_stall);
    else n_pass++;
    next_cycle();
    re_mem = 1'b0;
    #2;
    rst = 1'b0;
    next_cycle();
    do_access(1'b1, 64'h7010, 64'h0, 3'b010, 2, rnd64(), "lw_after_rst");
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, 64'h8004, rnd64(), 3'b010, 1, rnd64(), "b2b_sw");
    do_access(1'b1, 64'h8006, 64'h0, 3'b001, 2, rnd64(), "b2b_lh");
    do_access(1'b1, 64'h8000, 64'h0, 3'b011, 1, rnd64(), "b2b_ld");
  endtask

  task automatic test_random();
    logic       is_load;
    logic [2:0] f3;
    int         n;
    for (int i = 0; i < 24; i++) begin
      is_load = $urandom_range(0, 1);
      f3      = is_load ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
      n       = 1 << f3[1:0];
      do_access(is_load, rnd64() & ~64'(n - 1), rnd64(), f3, $urandom_range(1, TMO - 1),
                rnd64(), "rand");
      if ($urandom_range(0, 1) == 1) begin
        #2;
        n_checks++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0)
          $display("FAIL rand_gap req/stall got %b%b want 00", dmem_req, mem_stall);
        else n_pass++;
        next_cycle();
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_misalign();
    test_flush_drop();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
